// File: rtl/transition_energy_monitor.sv
// rtl/transition_energy_monitor.sv - windowed 0->1 transition counter with energy report
//
// Samples N_SIG gate outputs every clk and counts rising (0->1) transitions.
// Each WIN_LEN-cycle window produces one report (count and count*E_PER_TRANS)
// that is held on rpt_* under a valid/ready handshake until it is accepted.
// A saturating lifetime total and a sticky overrun flag are also kept.
//
// Optional feature macro: TEM_PEAK_TRACK_EN adds rpt_peak, the largest
// per-cycle rise count seen in the reported window.
//
// Ports:
//   clk          system clock, rising edge
//   reset_L      asynchronous active-low reset
//   enable       level, 1 = run measurement windows
//   clear        pulse, clears total_count and overrun
//   sig_in       monitored gate outputs
//   rpt_valid    window report available
//   rpt_ready    consumer accepts report
//   rpt_count    rising transitions in the reported window (saturating)
//   rpt_energy   rpt_count * E_PER_TRANS (saturating)
//   total_count  lifetime rising transitions counted while measuring (saturating)
//   overrun      sticky, a rise was dropped while a report was pending
//   rpt_peak     (TEM_PEAK_TRACK_EN only) peak per-cycle rises in the window
module transition_energy_monitor #(
    parameter int N_SIG       = 4,
    parameter int CNT_W       = 16,
    parameter int WIN_LEN     = 64,
    parameter int E_PER_TRANS = 3,
    localparam int NR_W       = $clog2(N_SIG + 1)
) (
    input  logic               clk,
    input  logic               reset_L,
    input  logic               enable,
    input  logic               clear,
    input  logic [N_SIG-1:0]   sig_in,
    output logic               rpt_valid,
    input  logic               rpt_ready,
    output logic [CNT_W-1:0]   rpt_count,
    output logic [CNT_W+7:0]   rpt_energy,
    output logic [CNT_W-1:0]   total_count,
`ifdef TEM_PEAK_TRACK_EN
    output logic [NR_W-1:0]    rpt_peak,
`endif
    output logic               overrun
);

    localparam int WC_W = $clog2(WIN_LEN);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        REPORT  = 2'd2
    } state_t;

    state_t           state;
    logic [N_SIG-1:0] prev_q;
    logic [WC_W-1:0]  win_cnt;
    logic [CNT_W-1:0] win_trans;

    logic [N_SIG-1:0] rise;
    logic [NR_W-1:0]  nrise;
    logic [CNT_W:0]   win_sum;
    logic [CNT_W-1:0] win_next;
    logic [CNT_W:0]   tot_sum;
    logic [CNT_W-1:0] tot_next;
    logic [CNT_W+8:0] energy_full;
    logic [CNT_W+7:0] energy_next;

    assign rise = sig_in & ~prev_q;

    always_comb begin
        nrise = '0;
        for (int i = 0; i < N_SIG; i++) begin
            nrise = nrise + NR_W'(rise[i]);
        end
    end

    // One extra bit on each sum exposes overflow so the result can clamp.
    assign win_sum     = {1'b0, win_trans} + (CNT_W+1)'(nrise);
    assign win_next    = win_sum[CNT_W] ? '1 : win_sum[CNT_W-1:0];
    assign tot_sum     = {1'b0, total_count} + (CNT_W+1)'(nrise);
    assign tot_next    = tot_sum[CNT_W] ? '1 : tot_sum[CNT_W-1:0];

    // Energy is taken from the same saturated value that lands in rpt_count.
    assign energy_full = (CNT_W+9)'(win_next) * (CNT_W+9)'(E_PER_TRANS);
    assign energy_next = energy_full[CNT_W+8] ? '1 : energy_full[CNT_W+7:0];

`ifdef TEM_PEAK_TRACK_EN
    logic [NR_W-1:0] win_peak;
    logic [NR_W-1:0] peak_next;
    assign peak_next = (nrise > win_peak) ? nrise : win_peak;
`endif

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state       <= IDLE;
            prev_q      <= '0;
            win_cnt     <= '0;
            win_trans   <= '0;
            total_count <= '0;
            rpt_count   <= '0;
            rpt_energy  <= '0;
            rpt_valid   <= 1'b0;
            overrun     <= 1'b0;
`ifdef TEM_PEAK_TRACK_EN
            win_peak    <= '0;
            rpt_peak    <= '0;
`endif
        end else begin
            prev_q <= sig_in;
            case (state)
                IDLE: begin
                    if (enable) begin
                        state     <= MEASURE;
                        win_cnt   <= '0;
                        win_trans <= '0;
`ifdef TEM_PEAK_TRACK_EN
                        win_peak  <= '0;
`endif
                    end
                end
                MEASURE: begin
                    total_count <= tot_next;
                    // Loss of enable wins over the window-end test: no partial report.
                    if (!enable) begin
                        state     <= IDLE;
                        win_cnt   <= '0;
                        win_trans <= '0;
`ifdef TEM_PEAK_TRACK_EN
                        win_peak  <= '0;
`endif
                    end else if (win_cnt == WC_W'(WIN_LEN - 1)) begin
                        state      <= REPORT;
                        rpt_count  <= win_next;
                        rpt_energy <= energy_next;
                        rpt_valid  <= 1'b1;
                        win_cnt    <= '0;
                        win_trans  <= '0;
`ifdef TEM_PEAK_TRACK_EN
                        rpt_peak   <= peak_next;
                        win_peak   <= '0;
`endif
                    end else begin
                        win_cnt   <= win_cnt + 1'b1;
                        win_trans <= win_next;
`ifdef TEM_PEAK_TRACK_EN
                        win_peak  <= peak_next;
`endif
                    end
                end
                REPORT: begin
                    if (nrise != '0) begin
                        overrun <= 1'b1;
                    end
                    if (rpt_ready) begin
                        rpt_valid <= 1'b0;
                        state     <= enable ? MEASURE : IDLE;
                        win_cnt   <= '0;
                        win_trans <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
            // Clear overrides any same-cycle increment or overrun set.
            if (clear) begin
                total_count <= '0;
                overrun     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_transition_energy_monitor.sv
// tb/tb_transition_energy_monitor.sv - directed bench with reference model for transition_energy_monitor
module tb_transition_energy_monitor;

    localparam int WIN = 8;
    localparam int EPT = 3;

    logic       clk = 1'b0;
    logic       reset_L = 1'b0;
    logic       enable = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] sig_in = 4'h0;
    logic       rpt_ready = 1'b0;

    logic        a_rv, a_ovr;
    logic [15:0] a_rc, a_tot;
    logic [23:0] a_re;
    logic        b_rv, b_ovr;
    logic [3:0]  b_rc, b_tot;
    logic [11:0] b_re;
`ifdef TEM_PEAK_TRACK_EN
    logic [2:0]  a_pk, b_pk;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    transition_energy_monitor #(.N_SIG(4), .CNT_W(16), .WIN_LEN(WIN), .E_PER_TRANS(EPT)) dut_a (
        .clk(clk), .reset_L(reset_L), .enable(enable), .clear(clear), .sig_in(sig_in),
        .rpt_valid(a_rv), .rpt_ready(rpt_ready), .rpt_count(a_rc), .rpt_energy(a_re),
        .total_count(a_tot),
`ifdef TEM_PEAK_TRACK_EN
        .rpt_peak(a_pk),
`endif
        .overrun(a_ovr));

    transition_energy_monitor #(.N_SIG(4), .CNT_W(4), .WIN_LEN(WIN), .E_PER_TRANS(EPT)) dut_b (
        .clk(clk), .reset_L(reset_L), .enable(enable), .clear(clear), .sig_in(sig_in),
        .rpt_valid(b_rv), .rpt_ready(rpt_ready), .rpt_count(b_rc), .rpt_energy(b_re),
        .total_count(b_tot),
`ifdef TEM_PEAK_TRACK_EN
        .rpt_peak(b_pk),
`endif
        .overrun(b_ovr));

    // Reference model: unbounded window sum and lifetime total, clamped only
    // when compared, so saturation falls out of plain min() arithmetic.
    int         m_mode;      // 0 idle, 1 measuring, 2 report pending
    logic [3:0] m_prev;
    int         m_age, m_sum, m_total, m_rc, m_pk, m_rpk, n;
    bit         m_rv, m_ovr;

    always @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            m_mode = 0; m_prev = 4'h0; m_age = 0; m_sum = 0; m_total = 0;
            m_rc = 0; m_pk = 0; m_rpk = 0; m_rv = 1'b0; m_ovr = 1'b0;
        end else begin
            n = $countones(sig_in & ~m_prev);
            m_prev = sig_in;
            if (m_mode == 0) begin
                if (enable) begin m_mode = 1; m_age = 0; m_sum = 0; m_pk = 0; end
            end else if (m_mode == 1) begin
                m_total += n;
                if (!enable) begin
                    m_mode = 0;
                end else if (m_age == WIN - 1) begin
                    m_rc = m_sum + n; m_rpk = (n > m_pk) ? n : m_pk;
                    m_rv = 1'b1; m_mode = 2;
                end else begin
                    m_sum += n; m_age++; if (n > m_pk) m_pk = n;
                end
            end else begin
                if (n != 0) m_ovr = 1'b1;
                if (rpt_ready) begin
                    m_rv = 1'b0; m_age = 0; m_sum = 0; m_pk = 0;
                    m_mode = enable ? 1 : 0;
                end
            end
            if (clear) begin m_total = 0; m_ovr = 1'b0; end
        end
    end

    function automatic longint clamp(longint v, longint mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("a_valid",  a_rv,  m_rv);
        chk("a_count",  a_rc,  clamp(m_rc, 65535));
        chk("a_energy", a_re,  clamp(EPT * clamp(m_rc, 65535), 24'hFFFFFF));
        chk("a_total",  a_tot, clamp(m_total, 65535));
        chk("a_ovr",    a_ovr, m_ovr);
        chk("b_valid",  b_rv,  m_rv);
        chk("b_count",  b_rc,  clamp(m_rc, 15));
        chk("b_energy", b_re,  clamp(EPT * clamp(m_rc, 15), 12'hFFF));
        chk("b_total",  b_tot, clamp(m_total, 15));
        chk("b_ovr",    b_ovr, m_ovr);
`ifdef TEM_PEAK_TRACK_EN
        chk("a_peak",   a_pk,  m_rpk);
        chk("b_peak",   b_pk,  m_rpk);
`endif
    end

    task automatic tick(input logic [3:0] s, input logic en, input logic rdy, input logic clr);
        sig_in = s; enable = en; rpt_ready = rdy; clear = clr;
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        reset_L = 1'b1;

        // Window of alternating 1111/0000: 16 rises.
        tick(4'h0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < WIN; i++) tick((i % 2 == 0) ? 4'hF : 4'h0, 1'b1, 1'b0, 1'b0);
        chk("lit_a_valid", a_rv, 1);
        chk("lit_a_count", a_rc, 16);
        chk("lit_a_energy", a_re, 48);
        chk("lit_a_total", a_tot, 16);
        chk("lit_b_count_sat", b_rc, 15);
        chk("lit_b_energy_sat", b_re, 45);
        chk("lit_b_total_sat", b_tot, 15);
`ifdef TEM_PEAK_TRACK_EN
        chk("lit_a_peak", a_pk, 4);
`endif

        // Consumer stalls while inputs keep toggling.
        for (int i = 0; i < 5; i++) tick((i % 2 == 0) ? 4'hF : 4'h0, 1'b1, 1'b0, 1'b0);
        chk("lit_hold_count", a_rc, 16);
        chk("lit_hold_overrun", a_ovr, 1);
        chk("lit_hold_total", a_tot, 16);
        tick(4'h0, 1'b1, 1'b1, 1'b0);
        chk("lit_accept_valid", a_rv, 0);

        // Abort part-way through a window, then idle.
        for (int i = 0; i < 4; i++) tick((i % 2 == 0) ? 4'hF : 4'h0, 1'b1, 1'b0, 1'b0);
        tick(4'hF, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) tick(4'h0, 1'b0, 1'b0, 1'b0);
        chk("lit_abort_valid", a_rv, 0);

        // Fresh window after re-enable: report appears on exactly the 8th edge.
        tick(4'h0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < WIN - 1; i++) tick((i % 2 == 0) ? 4'h5 : 4'h0, 1'b1, 1'b0, 1'b0);
        chk("lit_latency_early", a_rv, 0);
        tick(4'h0, 1'b1, 1'b0, 1'b0);
        chk("lit_latency_on", a_rv, 1);
        chk("lit_win2_count", a_rc, 8);

        // Clear in the same cycle as two rises.
        tick(4'h0, 1'b1, 1'b1, 1'b0);
        tick(4'h0, 1'b1, 1'b0, 1'b0);
        tick(4'h3, 1'b1, 1'b0, 1'b1);
        chk("lit_clear_total", a_tot, 0);
        chk("lit_clear_ovr", a_ovr, 0);
        for (int i = 0; i < WIN - 2; i++) tick(4'h3, 1'b1, 1'b0, 1'b0);
        chk("lit_clear_rpt_valid", a_rv, 1);
        chk("lit_clear_rpt_count", a_rc, 2);

        // Asynchronous reset between edges while a report is pending.
        #2 reset_L = 1'b0;
        #1;
        chk("lit_rst_valid", a_rv, 0);
        chk("lit_rst_count", a_rc, 0);
        chk("lit_rst_energy", a_re, 0);
        chk("lit_rst_total", a_tot, 0);
        @(negedge clk);
        reset_L = 1'b1;
        tick(4'h0, 1'b0, 1'b0, 1'b0);
        tick(4'h0, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/transition_energy_monitor.md
Name: transition_energy_monitor

Overview:
- Sequential stage directly downstream of the gate-level NAND/logic cells. Samples up to N_SIG gate outputs on clk and counts 0->1 output transitions, which are the energy-consuming events.
- Accumulates per-window transition counts and converts each count to an energy figure.
- Reports each window result to the power-estimation consumer over a valid/ready handshake.
- Also keeps a saturating lifetime transition total.

Parameters:
- N_SIG, 4, number of monitored gate outputs.
- CNT_W, 16, width of the window and lifetime transition counters.
- WIN_LEN, 64, measurement window length in clk cycles. Must be >= 2.
- E_PER_TRANS, 3, energy units charged per 0->1 transition. Unsigned, 8-bit max.

Ports:
- clk  in  1  single system clock, rising edge.
- reset_L  in  1  asynchronous, active-low reset.
- enable  in  1  level; 1 = run measurement windows.
- clear  in  1  synchronous pulse; clears lifetime total and sticky flag.
- sig_in  in  N_SIG  monitored gate outputs, sampled on clk.
- rpt_valid  out  1  window report available.
- rpt_ready  in  1  consumer accepts report.
- rpt_count  out  CNT_W  0->1 transitions in the reported window.
- rpt_energy  out  CNT_W+8  rpt_count*E_PER_TRANS, saturating.
- total_count  out  CNT_W  lifetime transitions, saturating.
- overrun  out  1  sticky: a transition was lost while a report was pending.

Behaviour:
- Reset (reset_L=0, async): state=IDLE; prev_q, win_cnt, win_trans, total_count, rpt_count, rpt_energy, overrun all 0; rpt_valid=0.
- Edge detect: prev_q<=sig_in every clk in every state. rise = sig_in & ~prev_q; nrise = popcount(rise), width clog2(N_SIG+1).
- A signal already high at the first clk after reset counts as a rise if the state is MEASURE.
- IDLE: no counting. If enable=1 -> MEASURE next cycle with win_cnt=0, win_trans=0.
- MEASURE: win_trans += nrise, saturating at 2^CNT_W-1. win_cnt increments each cycle.
- MEASURE, win_cnt==WIN_LEN-1: next state REPORT. rpt_count <= sat(win_trans+nrise). rpt_energy <= sat(rpt_count*E_PER_TRANS) computed from that same value. rpt_valid <= 1. Latency is WIN_LEN cycles from window start to rpt_valid rising.
- MEASURE, enable=0 (checked before the window-end test): abort to IDLE, clear win_cnt and win_trans, produce no report.
- REPORT: rpt_valid held at 1; rpt_count and rpt_energy stable until accepted.
- REPORT: rises are not counted into any window. If nrise!=0, set overrun=1.
- REPORT, rpt_valid & rpt_ready: rpt_valid <= 0. Go to MEASURE (counters zeroed) if enable=1, else IDLE.
- REPORT: enable=0 does not abort a pending report.
- total_count: += nrise only in MEASURE, saturating.
- clear=1: total_count <= 0 and overrun <= 0. This takes priority over the same-cycle increment or set. clear does not affect the state, the window counters or the report registers.
- Only reset_L reinitialises everything. Asserting reset_L=0 mid-window or mid-REPORT drops the report immediately (rpt_valid=0).

Optional Feature:
- Macro: TEM_PEAK_TRACK_EN.
- Defined: extra output rpt_peak [clog2(N_SIG+1)-1:0] holding the maximum nrise seen in any single cycle of the reported window, including the last cycle. It updates with rpt_count and is reset to 0.
- Undefined: port and logic absent. All other behaviour is identical.

Test Plan (N_SIG=4, WIN_LEN=8, E_PER_TRANS=3):
- Reset mid-activity: drive reset_L=0 asynchronously between clk edges -> all outputs 0 immediately, state IDLE.
- enable=1; sig_in toggles 0000->1111->0000 every cycle over 8 cycles -> rpt_valid after 8 cycles, rpt_count=16, rpt_energy=48, total_count=16. With TEM_PEAK_TRACK_EN, rpt_peak=4.
- Hold rpt_ready=0 for 5 cycles with sig_in toggling -> rpt_count/rpt_energy stable, overrun=1, total_count unchanged. rpt_ready=1 -> next window starts, win counters 0.
- Drop enable at cycle 4 of a window -> IDLE, no rpt_valid. Re-enable -> fresh 8-cycle window.
- CNT_W=4, continuous 4 rises/cycle -> total_count and rpt_count saturate at 15, rpt_energy=45, no wrap.
- clear=1 in the same cycle as nrise=2 during MEASURE -> total_count=0 next cycle. Window count still includes the 2.
